// File: rtl/keypad_hex_scanner.sv
// -----------------------------------------------------------------------------
// keypad_hex_scanner
//   Scans a 4x4 active-low hex keypad and debounces it. Each accepted key is
//   shifted into an 8-digit hex number, with the newest digit in the low
//   nibble. This is the input-side partner of the 8-digit hex display driver.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-high reset (highest priority)
//   FILAS[3:0]     keypad rows, active-low, bit r = row r
//   COLUMNAS[3:0]  column drive, active-low one-hot, bit c = column c
//   clear          synchronous clear of the entered number
//   numero_salida  entered number, digit 0 in [3:0]
//   digito         code of the last accepted key
//   digito_valido  one-cycle pulse when a key is accepted
//   num_digitos    digits entered, 0..8, saturating
// -----------------------------------------------------------------------------
module keypad_hex_scanner #(
    parameter int SCAN_TICKS     = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  FILAS,
    output logic [3:0]  COLUMNAS,
    input  logic        clear,
    output logic [31:0] numero_salida,
    output logic [3:0]  digito,
    output logic        digito_valido,
    output logic [3:0]  num_digitos
);

    localparam int TICK_W = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
    localparam int CNT_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Scan-result bit index is c*4 + r (column-major, matches latch order).
    function automatic logic [3:0] key_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h4;
            4'd2:    code = 4'h7;
            4'd3:    code = 4'hE;
            4'd4:    code = 4'h2;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h8;
            4'd7:    code = 4'h0;
            4'd8:    code = 4'h3;
            4'd9:    code = 4'h6;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hF;
            4'd12:   code = 4'hA;
            4'd13:   code = 4'hB;
            4'd14:   code = 4'hC;
            4'd15:   code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [4:0] count_ones(input logic [15:0] bits);
        logic [4:0] total;
        total = 5'd0;
        for (int i = 0; i < 16; i++) begin
            total = total + {4'd0, bits[i]};
        end
        return total;
    endfunction

    // Only meaningful when exactly one bit is set.
    function automatic logic [3:0] set_index(input logic [15:0] bits);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (bits[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [TICK_W-1:0] tick_r;
    logic [1:0]        col_r;
    logic [1:0]        col_next_s;
    logic              tick_last_s;
    logic [11:0]       row_bits_r;     // columns 0..2 of the scan in progress
    logic [15:0]       scan_bits_r;    // completed full scan
    logic              scan_done_r;    // one cycle after column 3 is sampled

    logic [4:0]        scan_ones_s;
    logic              scan_none_s;
    logic              scan_single_s;
    logic [3:0]        scan_code_s;

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        cand_r;
    logic [3:0]        cand_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              accept_s;

    assign tick_last_s = (tick_r == TICK_LAST);
    assign col_next_s  = col_r + 2'd1;

    // Column timing, row sampling on the last tick of each column, scan capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_r      <= '0;
            col_r       <= 2'd0;
            COLUMNAS    <= 4'b1110;
            row_bits_r  <= 12'd0;
            scan_bits_r <= 16'd0;
            scan_done_r <= 1'b0;
        end else begin
            scan_done_r <= 1'b0;
            if (tick_last_s) begin
                tick_r   <= '0;
                col_r    <= col_next_s;
                // Drive is registered with the next column so the rows have a
                // whole column period to settle before they are sampled.
                COLUMNAS <= ~(4'b0001 << col_next_s);
                case (col_r)
                    2'd0:    row_bits_r[3:0]  <= ~FILAS;
                    2'd1:    row_bits_r[7:4]  <= ~FILAS;
                    2'd2:    row_bits_r[11:8] <= ~FILAS;
                    default: begin
                        scan_bits_r <= {~FILAS, row_bits_r};
                        scan_done_r <= 1'b1;
                    end
                endcase
            end else begin
                tick_r <= tick_r + TICK_W'(1);
            end
        end
    end

    // Classify the completed scan: none / single key (with code) / multiple.
    always_comb begin
        scan_ones_s   = count_ones(scan_bits_r);
        scan_none_s   = (scan_ones_s == 5'd0);
        scan_single_s = (scan_ones_s == 5'd1);
        scan_code_s   = key_code(set_index(scan_bits_r));
        cnt_inc_s     = cnt_r + CNT_ONE;
    end

    // FSM state register together with the debounce candidate and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cand_r  <= 4'h0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cand_r  <= cand_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // FSM next-state logic, evaluated only when a full scan completes.
    always_comb begin
        state_next_s = state_r;
        cand_next_s  = cand_r;
        cnt_next_s   = cnt_r;
        if (scan_done_r) begin
            case (state_r)
                ST_IDLE: begin
                    if (scan_single_s) begin
                        cand_next_s = scan_code_s;
                        cnt_next_s  = CNT_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next_s = ST_PRESSED;
                        end else begin
                            state_next_s = ST_DEBOUNCE;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (scan_single_s) begin
                        if (scan_code_s == cand_r) begin
                            cnt_next_s = cnt_inc_s;
                            if (cnt_inc_s == CNT_DONE) begin
                                state_next_s = ST_PRESSED;
                            end else begin
                                state_next_s = ST_DEBOUNCE;
                            end
                        end else begin
                            cand_next_s  = scan_code_s;
                            cnt_next_s   = CNT_ONE;
                            state_next_s = ST_DEBOUNCE;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_PRESSED: begin
                    if (scan_none_s) begin
                        cnt_next_s = CNT_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_next_s = ST_IDLE;
                        end else begin
                            state_next_s = ST_RELEASE;
                        end
                    end else begin
                        state_next_s = ST_PRESSED;
                    end
                end
                ST_RELEASE: begin
                    if (scan_none_s) begin
                        cnt_next_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_DONE) begin
                            state_next_s = ST_IDLE;
                        end else begin
                            state_next_s = ST_RELEASE;
                        end
                    end else begin
                        state_next_s = ST_PRESSED;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM output decode: a key is accepted on the scan that completes debounce.
    always_comb begin
        accept_s = 1'b0;
        if (scan_done_r && scan_single_s) begin
            case (state_r)
                ST_IDLE:     accept_s = (DEBOUNCE_SCANS == 1);
                ST_DEBOUNCE: accept_s = (scan_code_s == cand_r) && (cnt_inc_s == CNT_DONE);
                default:     accept_s = 1'b0;
            endcase
        end else begin
            accept_s = 1'b0;
        end
    end

    // Registered outputs; clear beats a coincident accept for the number only.
    always_ff @(posedge clk) begin
        if (reset) begin
            numero_salida <= 32'd0;
            digito        <= 4'h0;
            digito_valido <= 1'b0;
            num_digitos   <= 4'd0;
        end else begin
            digito_valido <= accept_s;
            if (accept_s) begin
                digito <= scan_code_s;
            end
            if (clear) begin
                numero_salida <= 32'd0;
                num_digitos   <= 4'd0;
            end else if (accept_s) begin
                numero_salida <= {numero_salida[27:0], scan_code_s};
                if (num_digitos != 4'd8) begin
                    num_digitos <= num_digitos + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_hex_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_hex_scanner
//   Directed bench for keypad_hex_scanner with SCAN_TICKS=4, DEBOUNCE_SCANS=2
//   (one full scan = 16 cycles). A keypad model pulls a row low while the
//   matching column is driven and the key is held in key_mask (bit r*4+c).
// -----------------------------------------------------------------------------
module tb_keypad_hex_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic        clear;
    logic [31:0] numero_salida;
    logic [3:0]  digito;
    logic        digito_valido;
    logic [3:0]  num_digitos;

    logic [15:0] key_mask;
    int          n_cmp;
    int          n_err;
    int          pulse_count;

    keypad_hex_scanner #(
        .SCAN_TICKS     (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .FILAS         (filas),
        .COLUMNAS      (columnas),
        .clear         (clear),
        .numero_salida (numero_salida),
        .digito        (digito),
        .digito_valido (digito_valido),
        .num_digitos   (num_digitos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: held key at (r,c) pulls row r low while column c is driven.
    always_comb begin
        filas = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (columnas[c] == 1'b0 && key_mask[r*4+c]) begin
                    filas[r] = 1'b0;
                end
            end
        end
    end

    // Count accept pulses.
    always @(negedge clk) begin
        if (digito_valido === 1'b1) begin
            pulse_count <= pulse_count + 1;
        end
    end

    // Keypad layout -> mask bit r*4+c.
    function automatic logic [15:0] key_bit(input logic [3:0] code);
        logic [15:0] m;
        case (code)
            4'h1: m = 16'h0001;  4'h2: m = 16'h0002;  4'h3: m = 16'h0004;  4'hA: m = 16'h0008;
            4'h4: m = 16'h0010;  4'h5: m = 16'h0020;  4'h6: m = 16'h0040;  4'hB: m = 16'h0080;
            4'h7: m = 16'h0100;  4'h8: m = 16'h0200;  4'h9: m = 16'h0400;  4'hC: m = 16'h0800;
            4'hE: m = 16'h1000;  4'h0: m = 16'h2000;  4'hF: m = 16'h4000;  4'hD: m = 16'h8000;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    // Leaves the bench at the negedge right after COLUMNAS returns to 1110.
    task automatic wait_scan_start();
        int guard;
        guard = 0;
        while (columnas !== 4'b0111 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        while (columnas !== 4'b1110 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 200) begin
            n_err++;
            $display("FAIL scan_start_timeout: COLUMNAS=%b, required 0111 then 1110", columnas);
        end
    endtask

    task automatic hold(input logic [15:0] mask, input int scans);
        key_mask = mask;
        repeat (16 * scans) @(negedge clk);
    endtask

    // Edges from the current negedge until digito_valido is seen high.
    task automatic measure_latency(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (digito_valido !== 1'b1 && lat < 200);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (columnas !== 4'b1110 || numero_salida !== 32'd0 || digito !== 4'h0 ||
                digito_valido !== 1'b0 || num_digitos !== 4'd0) begin
                n_err++;
                $display("FAIL reset_state: cols=%b num=%h dig=%h v=%b nd=%0d, required 1110/0/0/0/0",
                         columnas, numero_salida, digito, digito_valido, num_digitos);
            end
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (columnas !== 4'b1110) begin
            n_err++;
            $display("FAIL col0_hold: COLUMNAS=%b, required 1110", columnas);
        end
        @(negedge clk);
        n_cmp++;
        if (columnas !== 4'b1101) begin
            n_err++;
            $display("FAIL col1: COLUMNAS=%b, required 1101", columnas);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (columnas !== 4'b1011) begin
            n_err++;
            $display("FAIL col2: COLUMNAS=%b, required 1011", columnas);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (columnas !== 4'b0111) begin
            n_err++;
            $display("FAIL col3: COLUMNAS=%b, required 0111", columnas);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (columnas !== 4'b1110) begin
            n_err++;
            $display("FAIL col_wrap: COLUMNAS=%b, required 1110", columnas);
        end
    endtask

    task automatic test_single_press();
        int lat;
        int base;
        base = pulse_count;
        wait_scan_start();
        key_mask = key_bit(4'h6);
        measure_latency(lat);
        n_cmp++;
        if (lat != 33) begin
            n_err++;
            $display("FAIL press6_latency: %0d cycles, required 33", lat);
        end
        n_cmp++;
        if (digito !== 4'h6 || numero_salida !== 32'h00000006 || num_digitos !== 4'd1) begin
            n_err++;
            $display("FAIL press6_outputs: dig=%h num=%h nd=%0d, required 6/00000006/1",
                     digito, numero_salida, num_digitos);
        end
        repeat (80 - 33) @(negedge clk);
        hold(16'h0000, 3);
        n_cmp++;
        if (pulse_count - base != 1) begin
            n_err++;
            $display("FAIL press6_pulses: %0d, required 1", pulse_count - base);
        end
    endtask

    task automatic test_sequence();
        int base;
        logic [3:0] k;
        base = pulse_count;
        wait_scan_start();
        for (int i = 1; i <= 9; i++) begin
            k = 4'(i);
            hold(key_bit(k), 3);
            hold(16'h0000, 3);
            n_cmp++;
            if (digito !== k) begin
                n_err++;
                $display("FAIL seq_digit_%0d: dig=%h, required %h", i, digito, k);
            end
            if (i == 7) begin
                n_cmp++;
                if (numero_salida !== 32'h61234567 || num_digitos !== 4'd8) begin
                    n_err++;
                    $display("FAIL seq_full8: num=%h nd=%0d, required 61234567/8",
                             numero_salida, num_digitos);
                end
            end
        end
        n_cmp++;
        if (numero_salida !== 32'h23456789 || num_digitos !== 4'd8) begin
            n_err++;
            $display("FAIL seq_final: num=%h nd=%0d, required 23456789/8", numero_salida, num_digitos);
        end
        n_cmp++;
        if (pulse_count - base != 9) begin
            n_err++;
            $display("FAIL seq_pulses: %0d, required 9", pulse_count - base);
        end
    endtask

    task automatic test_bounce();
        int base;
        wait_scan_start();
        base = pulse_count;
        hold(key_bit(4'h0), 1);
        hold(16'h0000, 3);
        n_cmp++;
        if (pulse_count - base != 0) begin
            n_err++;
            $display("FAIL bounce_short: %0d pulses, required 0", pulse_count - base);
        end
        base = pulse_count;
        hold(key_bit(4'h0), 3);
        hold(16'h0000, 1);
        hold(key_bit(4'h0), 3);
        hold(16'h0000, 3);
        n_cmp++;
        if (pulse_count - base != 1 || numero_salida !== 32'h34567890) begin
            n_err++;
            $display("FAIL bounce_dropout: %0d pulses num=%h, required 1/34567890",
                     pulse_count - base, numero_salida);
        end
        base = pulse_count;
        hold(key_bit(4'h1) | key_bit(4'h2), 3);
        hold(16'h0000, 3);
        n_cmp++;
        if (pulse_count - base != 0 || numero_salida !== 32'h34567890) begin
            n_err++;
            $display("FAIL bounce_multi: %0d pulses num=%h, required 0/34567890",
                     pulse_count - base, numero_salida);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (numero_salida !== 32'd0 || num_digitos !== 4'd0 || digito !== 4'h0) begin
            n_err++;
            $display("FAIL clear_idle: num=%h nd=%0d dig=%h, required 0/0/0",
                     numero_salida, num_digitos, digito);
        end
        wait_scan_start();
        hold(key_bit(4'h1), 3);
        hold(16'h0000, 3);
        hold(key_bit(4'h2), 3);
        hold(16'h0000, 3);
        n_cmp++;
        if (numero_salida !== 32'h00000012 || num_digitos !== 4'd2) begin
            n_err++;
            $display("FAIL clear_pre: num=%h nd=%0d, required 00000012/2", numero_salida, num_digitos);
        end
        key_mask = key_bit(4'hA);
        repeat (32) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (numero_salida !== 32'd0 || num_digitos !== 4'd0 || digito_valido !== 1'b1 || digito !== 4'hA) begin
            n_err++;
            $display("FAIL clear_accept: num=%h nd=%0d v=%b dig=%h, required 0/0/1/A",
                     numero_salida, num_digitos, digito_valido, digito);
        end
        repeat (15) @(negedge clk);
        hold(16'h0000, 3);
        hold(key_bit(4'hB), 3);
        hold(16'h0000, 3);
        n_cmp++;
        if (numero_salida !== 32'h0000000B || num_digitos !== 4'd1) begin
            n_err++;
            $display("FAIL clear_after: num=%h nd=%0d, required 0000000B/1", numero_salida, num_digitos);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int lat;
        wait_scan_start();
        key_mask = key_bit(4'hC);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (numero_salida !== 32'd0 || digito !== 4'h0 || digito_valido !== 1'b0 ||
            num_digitos !== 4'd0 || columnas !== 4'b1110) begin
            n_err++;
            $display("FAIL rst_mid_outputs: num=%h dig=%h v=%b nd=%0d cols=%b, required 0/0/0/0/1110",
                     numero_salida, digito, digito_valido, num_digitos, columnas);
        end
        reset = 1'b0;
        measure_latency(lat);
        n_cmp++;
        if (lat != 33 || digito !== 4'hC || numero_salida !== 32'h0000000C || num_digitos !== 4'd1) begin
            n_err++;
            $display("FAIL rst_mid_repress: lat=%0d dig=%h num=%h nd=%0d, required 33/C/0000000C/1",
                     lat, digito, numero_salida, num_digitos);
        end
        repeat (15) @(negedge clk);
        hold(16'h0000, 3);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        pulse_count = 0;
        key_mask    = 16'h0000;
        clear       = 1'b0;
        reset       = 1'b1;
        test_reset();
        test_single_press();
        test_sequence();
        test_bounce();
        test_clear();
        test_reset_mid_debounce();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
